// File: rtl/timer_ctrl.sv
// timer_ctrl: configuration registers, prescaler and run/hold/idle sequencer
// for a BIT-wide count with one-shot or periodic terminal-count events.
module timer_ctrl #(
    parameter int BIT     = 8,
    parameter int PRE_BIT = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CFG_WE,
    input  logic [BIT-1:0]     CFG_PERIOD,
    input  logic [PRE_BIT-1:0] CFG_PRESCALE,
    input  logic               CFG_MODE,
    input  logic               START,
    input  logic               STOP,
    input  logic               HOLD,
    output logic [BIT-1:0]     cnt,
    output logic               TICK,
    output logic               DONE,
    output logic               BUSY,
    output logic [1:0]         STATE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t             state;
    logic [BIT-1:0]     period_r;
    logic [PRE_BIT-1:0] prescale_r;
    logic               mode_r;
    logic [PRE_BIT-1:0] presc;

    assign STATE = state;

    // Sequencer: config load, start/stop/hold priority, prescaler and count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            period_r   <= '0;
            prescale_r <= '0;
            mode_r     <= 1'b0;
            presc      <= '0;
            cnt        <= '0;
            TICK       <= 1'b0;
            DONE       <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            TICK <= 1'b0;
            DONE <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (CFG_WE) begin
                        period_r   <= CFG_PERIOD;
                        prescale_r <= CFG_PRESCALE;
                        mode_r     <= CFG_MODE;
                    end
                    if (START) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        presc <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                // Leaving HOLD advances the prescaler on that same edge so the
                // pause costs exactly as many cycles as HOLD was high.
                ST_RUN, ST_HOLD: begin
                    if (STOP) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end else if (START) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        presc <= '0;
                    end else if (HOLD) begin
                        state <= ST_HOLD;
                    end else begin
                        state <= ST_RUN;
                        if (presc == prescale_r) begin
                            presc <= '0;
                            TICK  <= 1'b1;
                            if (cnt == period_r) begin
                                DONE <= 1'b1;
                                if (mode_r) begin
                                    cnt <= '0;
                                end else begin
                                    state <= ST_IDLE;
                                    BUSY  <= 1'b0;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed stimulus with per-edge expected outputs pushed to a
// scoreboard queue; an independent monitor pops and compares after each edge.
module tb_timer_ctrl;

    localparam logic [1:0] SI = 2'b00;
    localparam logic [1:0] SR = 2'b01;
    localparam logic [1:0] SH = 2'b10;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CFG_WE = 1'b0;
    logic [7:0] CFG_PERIOD = '0;
    logic [3:0] CFG_PRESCALE = '0;
    logic       CFG_MODE = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       HOLD = 1'b0;
    logic [7:0] cnt;
    logic       TICK;
    logic       DONE;
    logic       BUSY;
    logic [1:0] STATE;

    typedef struct packed {
        logic [7:0] c;
        logic       t;
        logic       d;
        logic       b;
        logic [1:0] s;
    } obs_t;

    typedef struct {
        obs_t v;
        int   tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    timer_ctrl #(.BIT(8), .PRE_BIT(4)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .CFG_WE       (CFG_WE),
        .CFG_PERIOD   (CFG_PERIOD),
        .CFG_PRESCALE (CFG_PRESCALE),
        .CFG_MODE     (CFG_MODE),
        .START        (START),
        .STOP         (STOP),
        .HOLD         (HOLD),
        .cnt          (cnt),
        .TICK         (TICK),
        .DONE         (DONE),
        .BUSY         (BUSY),
        .STATE        (STATE)
    );

    always #5 CLK = ~CLK;

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {cnt, TICK, DONE, BUSY, STATE};
                n_checks++;
                if (a !== e.v) begin
                    n_fail++;
                    $display("FAIL test%0d @%0t: got cnt=%0d tick=%b done=%b busy=%b state=%b, want cnt=%0d tick=%b done=%b busy=%b state=%b",
                             e.tag, $time, a.c, a.t, a.d, a.b, a.s, e.v.c, e.v.t, e.v.d, e.v.b, e.v.s);
                end
            end
        end
    end

    // One clock edge: record what the outputs must be after it, then release pulses.
    task automatic step(input int tag, input logic [7:0] c, input logic t,
                        input logic d, input logic b, input logic [1:0] s);
        exp_t e;
        @(posedge CLK);
        e.v = {c, t, d, b, s};
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge CLK);
        START  = 1'b0;
        STOP   = 1'b0;
        CFG_WE = 1'b0;
    endtask

    task automatic cfg(input logic [7:0] per, input logic [3:0] pre, input logic md);
        CFG_WE       = 1'b1;
        CFG_PERIOD   = per;
        CFG_PRESCALE = pre;
        CFG_MODE     = md;
    endtask

    initial begin
        @(negedge CLK);
        // 1: reset held two edges
        RST = 1'b1;
        step(1, 8'd0, 0, 0, 0, SI);
        step(1, 8'd0, 0, 0, 0, SI);
        RST = 1'b0;

        // 2: one-shot PERIOD=5 PRESCALE=0
        cfg(8'd5, 4'd0, 1'b0);
        step(2, 8'd0, 0, 0, 0, SI);
        START = 1'b1;
        step(2, 8'd0, 0, 0, 1, SR);
        for (int i = 1; i <= 5; i++) step(2, 8'(i), 1, 0, 1, SR);
        step(2, 8'd5, 1, 1, 0, SI);
        step(2, 8'd5, 0, 0, 0, SI);
        step(2, 8'd5, 0, 0, 0, SI);

        // 3: periodic PERIOD=3 PRESCALE=2, three full periods
        cfg(8'd3, 4'd2, 1'b1);
        step(3, 8'd5, 0, 0, 0, SI);
        START = 1'b1;
        step(3, 8'd0, 0, 0, 1, SR);
        for (int p = 0; p < 3; p++) begin
            for (int v = 0; v <= 3; v++) begin
                step(3, 8'(v), 0, 0, 1, SR);
                step(3, 8'(v), 0, 0, 1, SR);
                step(3, (v == 3) ? 8'd0 : 8'(v + 1), 1, (v == 3), 1, SR);
            end
        end
        STOP = 1'b1;
        step(3, 8'd0, 0, 0, 0, SI);

        // 4: STOP with START at cnt=2, then PERIOD=0 periodic
        cfg(8'd5, 4'd0, 1'b1);
        step(4, 8'd0, 0, 0, 0, SI);
        START = 1'b1;
        step(4, 8'd0, 0, 0, 1, SR);
        step(4, 8'd1, 1, 0, 1, SR);
        step(4, 8'd2, 1, 0, 1, SR);
        STOP = 1'b1;
        START = 1'b1;
        step(4, 8'd2, 0, 0, 0, SI);
        step(4, 8'd2, 0, 0, 0, SI);
        cfg(8'd0, 4'd0, 1'b1);
        step(4, 8'd2, 0, 0, 0, SI);
        START = 1'b1;
        step(4, 8'd0, 0, 0, 1, SR);
        for (int i = 0; i < 4; i++) step(4, 8'd0, 1, 1, 1, SR);
        STOP = 1'b1;
        step(4, 8'd0, 0, 0, 0, SI);

        // 5: one-shot PERIOD=5, config write ignored in RUN, HOLD for 4 edges at cnt=3
        cfg(8'd5, 4'd0, 1'b0);
        step(5, 8'd0, 0, 0, 0, SI);
        START = 1'b1;
        step(5, 8'd0, 0, 0, 1, SR);
        step(5, 8'd1, 1, 0, 1, SR);
        cfg(8'd9, 4'd3, 1'b1);
        step(5, 8'd2, 1, 0, 1, SR);
        step(5, 8'd3, 1, 0, 1, SR);
        HOLD = 1'b1;
        for (int i = 0; i < 4; i++) step(5, 8'd3, 0, 0, 1, SH);
        HOLD = 1'b0;
        step(5, 8'd4, 1, 0, 1, SR);
        step(5, 8'd5, 1, 0, 1, SR);
        step(5, 8'd5, 1, 1, 0, SI);

        // 6: STOP on the terminal-tick edge suppresses DONE
        START = 1'b1;
        step(6, 8'd0, 0, 0, 1, SR);
        for (int i = 1; i <= 5; i++) step(6, 8'(i), 1, 0, 1, SR);
        STOP = 1'b1;
        step(6, 8'd5, 0, 0, 0, SI);
        step(6, 8'd5, 0, 0, 0, SI);

        // 7: START on the terminal-tick edge restarts without DONE
        START = 1'b1;
        step(7, 8'd0, 0, 0, 1, SR);
        for (int i = 1; i <= 5; i++) step(7, 8'(i), 1, 0, 1, SR);
        START = 1'b1;
        step(7, 8'd0, 0, 0, 1, SR);
        STOP = 1'b1;
        step(7, 8'd0, 0, 0, 0, SI);

        // 8: PERIOD=255 periodic wraps to 0
        cfg(8'd255, 4'd0, 1'b1);
        step(8, 8'd0, 0, 0, 0, SI);
        START = 1'b1;
        step(8, 8'd0, 0, 0, 1, SR);
        for (int i = 1; i <= 255; i++) step(8, 8'(i), 1, 0, 1, SR);
        step(8, 8'd0, 1, 1, 1, SR);
        step(8, 8'd1, 1, 0, 1, SR);
        STOP = 1'b1;
        step(8, 8'd1, 0, 0, 0, SI);

        // 9: reset mid-RUN clears outputs and config (next run: PERIOD=0 one-shot)
        cfg(8'd7, 4'd1, 1'b1);
        step(9, 8'd1, 0, 0, 0, SI);
        START = 1'b1;
        step(9, 8'd0, 0, 0, 1, SR);
        step(9, 8'd0, 0, 0, 1, SR);
        step(9, 8'd1, 1, 0, 1, SR);
        step(9, 8'd1, 0, 0, 1, SR);
        RST = 1'b1;
        START = 1'b1;
        step(9, 8'd0, 0, 0, 0, SI);
        RST = 1'b0;
        START = 1'b1;
        step(9, 8'd0, 0, 0, 1, SR);
        step(9, 8'd0, 1, 1, 0, SI);
        step(9, 8'd0, 0, 0, 0, SI);

        repeat (3) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
